// File: rtl/integral_image_gen_if.sv
// rtl/integral_image_gen_if.sv - pixel-in / integral-out stream bundle for integral_image_gen
//
// Purpose: groups the pixel input handshake and the integral-image output
//          handshake so the producer and its neighbours share one port.
// Signals:
//   frame_start  next accepted pixel is (0,0)
//   pix_in       8-bit grayscale pixel, qualified by pix_valid
//   pix_valid    pixel source has a pixel
//   pix_ready    block accepts a pixel this cycle
//   ii_out       integral value at (out_x, out_y)
//   ii_sq_out    squared integral value at (out_x, out_y)
//   out_x/out_y  coordinates of the current output
//   out_valid    output register holds a result
//   out_ready    downstream accepts the output
//   out_last     output is the last pixel of the frame
// Modports: master drives pixels and consumes results, slave is the block.

interface integral_image_gen_if #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int II_W  = 18,
  parameter int SQ_W  = 32
);
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic            frame_start;
  logic [7:0]      pix_in;
  logic            pix_valid;
  logic            pix_ready;
  logic [II_W-1:0] ii_out;
  logic [SQ_W-1:0] ii_sq_out;
  logic [XW-1:0]   out_x;
  logic [YW-1:0]   out_y;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;

  modport master (
    output frame_start, pix_in, pix_valid, out_ready,
    input  pix_ready, ii_out, ii_sq_out, out_x, out_y, out_valid, out_last
  );

  modport slave (
    input  frame_start, pix_in, pix_valid, out_ready,
    output pix_ready, ii_out, ii_sq_out, out_x, out_y, out_valid, out_last
  );
endinterface

// File: rtl/integral_image_gen.sv
// rtl/integral_image_gen.sv - streaming integral and squared-integral image producer
//
// Purpose: takes raster-order 8-bit pixels and emits, one result per accepted
//          pixel, ii(x,y) and ii_sq(x,y) (inclusive sums over the rectangle
//          from (0,0)). A single line buffer holds the previous row's
//          integrals; the running row sums are kept in two accumulators.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    integral_image_gen_if.slave (pixel in, integral out, see interface)

module integral_image_gen #(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int II_W  = 18,
  parameter int SQ_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  integral_image_gen_if.slave  bus
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int LW = II_W + SQ_W;
  localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);

  // Position and row accumulators
  logic [XW-1:0]   x_cnt;
  logic [YW-1:0]   y_cnt;
  logic [II_W-1:0] row_sum;
  logic [SQ_W-1:0] row_sq;

  // Previous-row integrals, {ii, ii_sq} per column; no reset needed since
  // row 0 of every frame ignores the read value.
  logic [LW-1:0]   lb [IMG_W];

  // Output register
  logic            out_valid_q;
  logic            out_last_q;
  logic [II_W-1:0] ii_q;
  logic [SQ_W-1:0] sq_q;
  logic [XW-1:0]   ox_q;
  logic [YW-1:0]   oy_q;

  logic            accept;
  logic [XW-1:0]   cur_x;
  logic [YW-1:0]   cur_y;
  logic [XW-1:0]   x_nxt;
  logic [YW-1:0]   y_nxt;
  logic [15:0]     pix_sq;
  logic [II_W-1:0] row_sum_new;
  logic [SQ_W-1:0] row_sq_new;
  logic [LW-1:0]   lb_rd;
  logic [II_W-1:0] ii_new;
  logic [SQ_W-1:0] sq_new;
  logic            last_px;

  // Single output register: a pixel may enter whenever the slot is empty or
  // is being drained this cycle.
  assign bus.pix_ready = !out_valid_q || bus.out_ready;
  assign accept        = bus.pix_valid && bus.pix_ready;

  // frame_start coincident with a pixel makes that pixel (0,0).
  assign cur_x = bus.frame_start ? '0 : x_cnt;
  assign cur_y = bus.frame_start ? '0 : y_cnt;

  assign pix_sq      = {8'd0, bus.pix_in} * {8'd0, bus.pix_in};
  assign row_sum_new = ((cur_x == '0) ? '0 : row_sum) + II_W'(bus.pix_in);
  assign row_sq_new  = ((cur_x == '0) ? '0 : row_sq) + SQ_W'(pix_sq);

  // Read-before-write: the read here sees the value from the previous row.
  assign lb_rd  = lb[cur_x];
  assign ii_new = row_sum_new + ((cur_y == '0) ? '0 : lb_rd[LW-1:SQ_W]);
  assign sq_new = row_sq_new  + ((cur_y == '0) ? '0 : lb_rd[SQ_W-1:0]);

  assign last_px = (cur_x == X_MAX) && (cur_y == Y_MAX);

  always_comb begin
    x_nxt = cur_x + 1'b1;
    y_nxt = cur_y;
    if (cur_x == X_MAX) begin
      x_nxt = '0;
      y_nxt = (cur_y == Y_MAX) ? '0 : cur_y + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_sum <= '0;
      row_sq  <= '0;
    end else if (accept) begin
      x_cnt   <= x_nxt;
      y_cnt   <= y_nxt;
      row_sum <= row_sum_new;
      row_sq  <= row_sq_new;
    end else if (bus.frame_start) begin
      x_cnt   <= '0;
      y_cnt   <= '0;
      row_sum <= '0;
      row_sq  <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb[cur_x] <= {ii_new, sq_new};
    end
  end

  // A pending result is untouched by frame_start; only a new accept or a
  // downstream transfer changes the register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ii_q        <= '0;
      sq_q        <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_last_q  <= last_px;
      ii_q        <= ii_new;
      sq_q        <= sq_new;
      ox_q        <= cur_x;
      oy_q        <= cur_y;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.ii_out    = ii_q;
  assign bus.ii_sq_out = sq_q;
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;

endmodule
